// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the 64-bit mmu request interface.
// Backs a 2**DEPTH_LOG2 doubleword RAM and completes each request after a fixed
// number of wait states, signalling completion with a one-cycle mem_ready pulse.
//
// Handshake: a request (read_rq_to_memory or write_rq_to_memory high) is taken
// at any rising edge where the responder is not busy (IDLE or DONE). Address,
// data and op are sampled only at that edge; anything on the inputs while
// mem_busy is high is ignored and cannot cancel the op. Completion is the
// single cycle with mem_ready high; mem_fault and data_from_mem are valid in
// that cycle. A request held high through DONE is captured back-to-back.
module mem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        phi1,
    input  logic        rst_n,
    input  logic        read_rq_to_memory,
    input  logic        write_rq_to_memory,
    input  logic [55:0] addr_to_mem,
    input  logic [63:0] data_to_mem,
    output logic [63:0] data_from_mem,
    output logic        mem_busy,
    output logic        mem_ready,
    output logic        mem_fault
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter starts at LATENCY-1 so the commit lands LATENCY edges after capture.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
    logic                   oor_q, oor_d;
    logic                   is_wr_q, is_wr_d;
    logic [63:0]            wdata_q, wdata_d;
    logic [63:0]            rdata_q, rdata_d;
    logic                   busy_q, busy_d;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;

    logic [63:0]            ram [DEPTH];

    logic                   req_any;
    logic                   req_oor;
    logic                   commit;
    logic                   ram_we;
    logic                   unused_addr_lsbs;

    // Doubleword access: the byte offset within a word carries no meaning here.
    assign unused_addr_lsbs = ^addr_to_mem[2:0];

    assign req_any = read_rq_to_memory | write_rq_to_memory;
    // Any set bit above the RAM's byte range makes the address out of range.
    assign req_oor = |addr_to_mem[55:DEPTH_LOG2+3];

    assign commit  = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    // Out-of-range writes are dropped; a reset clears state_q so no write commits.
    assign ram_we  = commit && is_wr_q && !oor_q;

    // Next-state, capture and commit logic for the request FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        oor_d   = oor_q;
        is_wr_d = is_wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (req_any) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                    idx_d   = addr_to_mem[DEPTH_LOG2+2:3];
                    oor_d   = req_oor;
                    // Write wins when both requests are raised together.
                    is_wr_d = write_rq_to_memory;
                    wdata_d = data_to_mem;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    if (!is_wr_q) begin
                        rdata_d = oor_q ? 64'd0 : ram[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered copies of the state being entered.
        busy_d  = (state_d == ST_WAIT);
        ready_d = (state_d == ST_DONE);
        fault_d = (state_d == ST_DONE) ? oor_d : 1'b0;
    end

    // FSM and datapath registers, asynchronously cleared by rst_n.
    always_ff @(posedge phi1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            is_wr_q <= 1'b0;
            wdata_q <= 64'd0;
            rdata_q <= 64'd0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            oor_q   <= oor_d;
            is_wr_q <= is_wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
        end
    end

    // RAM array write port; contents survive reset.
    always_ff @(posedge phi1) begin
        if (ram_we) begin
            ram[idx_q] <= wdata_q;
        end
    end

    assign data_from_mem = rdata_q;
    assign mem_busy      = busy_q;
    assign mem_ready     = ready_q;
    assign mem_fault     = fault_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed plus randomized checks of mem_responder against a
// word-array reference model of the responder's memory and read data.
module tb_mem_responder;

  localparam int DL    = 10;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << DL;

  logic        phi1;
  logic        rst_n;
  logic        read_rq_to_memory;
  logic        write_rq_to_memory;
  logic [55:0] addr_to_mem;
  logic [63:0] data_to_mem;
  logic [63:0] data_from_mem;
  logic        mem_busy;
  logic        mem_ready;
  logic        mem_fault;

  int vectors;
  int miscompares;

  logic [63:0] ref_mem [int];
  logic [63:0] exp_rdata;

  mem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .phi1              (phi1),
    .rst_n             (rst_n),
    .read_rq_to_memory (read_rq_to_memory),
    .write_rq_to_memory(write_rq_to_memory),
    .addr_to_mem       (addr_to_mem),
    .data_to_mem       (data_to_mem),
    .data_from_mem     (data_from_mem),
    .mem_busy          (mem_busy),
    .mem_ready         (mem_ready),
    .mem_fault         (mem_fault)
  );

  // clock
  initial phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  task automatic check_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Quiet cycles: no request, responder must sit idle holding the last read data.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge phi1);
      read_rq_to_memory  = 1'b0;
      write_rq_to_memory = 1'b0;
      @(posedge phi1);
      #1;
      check_bit("idle_busy", mem_busy, 1'b0);
      check_bit("idle_ready", mem_ready, 1'b0);
      check_bit("idle_fault", mem_fault, 1'b0);
      check_word("idle_data", data_from_mem, exp_rdata);
    end
  endtask

  // One transaction: request presented for one edge, then the inputs are
  // scrambled (including spurious requests) while the responder is busy.
  task automatic txn(input bit wr, input logic [55:0] a, input logic [63:0] d);
    logic        exp_f;
    logic [63:0] prev_rdata;
    int          idx;
    @(negedge phi1);
    write_rq_to_memory = wr;
    read_rq_to_memory  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    addr_to_mem        = a;
    data_to_mem        = d;
    // reference model: byte address -> word, range = 2**(DL+3) bytes
    prev_rdata = exp_rdata;
    exp_f      = (a >> (DL + 3)) != 56'd0;
    idx        = int'((a >> 3) % 56'(DEPTH));
    if (exp_f) begin
      if (!wr) exp_rdata = 64'd0;
    end else if (wr) begin
      ref_mem[idx] = d;
    end else begin
      exp_rdata = ref_mem[idx];
    end
    @(posedge phi1);
    #1;
    check_bit("cap_busy", mem_busy, 1'b1);
    check_bit("cap_ready", mem_ready, 1'b0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge phi1);
      write_rq_to_memory = 1'($urandom_range(0, 1));
      read_rq_to_memory  = 1'($urandom_range(0, 1));
      addr_to_mem        = 56'({$urandom(), $urandom()});
      data_to_mem        = {$urandom(), $urandom()};
      @(posedge phi1);
      #1;
      if (k < LAT) begin
        check_bit("wait_busy", mem_busy, 1'b1);
        check_bit("wait_ready", mem_ready, 1'b0);
        check_word("wait_data", data_from_mem, prev_rdata);
      end
    end
    check_bit("done_ready", mem_ready, 1'b1);
    check_bit("done_busy", mem_busy, 1'b0);
    check_bit("done_fault", mem_fault, exp_f);
    check_word("done_data", data_from_mem, exp_rdata);
  endtask

  initial begin
    logic [55:0] ra;
    vectors            = 0;
    miscompares        = 0;
    exp_rdata          = 64'd0;
    rst_n              = 1'b0;
    read_rq_to_memory  = 1'b0;
    write_rq_to_memory = 1'b0;
    addr_to_mem        = 56'd0;
    data_to_mem        = 64'd0;

    // reset
    repeat (2) @(negedge phi1);
    #1;
    check_word("rst_data", data_from_mem, 64'd0);
    check_bit("rst_busy", mem_busy, 1'b0);
    check_bit("rst_ready", mem_ready, 1'b0);
    check_bit("rst_fault", mem_fault, 1'b0);
    @(negedge phi1);
    rst_n = 1'b1;
    idle(5);

    // preload words 0..15 so every later read has a known value
    for (int i = 0; i < 16; i++) txn(1'b1, 56'(i * 8), {$urandom(), $urandom()});
    idle(1);

    // write then read 0x40, then read with ignored byte offset
    txn(1'b1, 56'h40, 64'hDEAD_BEEF_CAFE_F00D);
    txn(1'b0, 56'h40, 64'd0);
    idle(1);
    txn(1'b0, 56'h47, 64'd0);
    idle(1);

    // back-to-back writes then reads
    txn(1'b1, 56'h10, 64'h1);
    txn(1'b1, 56'h20, 64'h2);
    txn(1'b0, 56'h10, 64'd0);
    txn(1'b0, 56'h20, 64'd0);
    idle(1);

    // out-of-range read and write
    txn(1'b0, 56'h2000, 64'd0);
    idle(1);
    txn(1'b1, 56'h2000, 64'h55);
    txn(1'b0, 56'h0, 64'd0);
    idle(1);

    // reset during an in-flight write to 0x8
    @(negedge phi1);
    write_rq_to_memory = 1'b1;
    read_rq_to_memory  = 1'b0;
    addr_to_mem        = 56'h8;
    data_to_mem        = 64'hAA;
    @(posedge phi1);
    #1;
    check_bit("abort_busy", mem_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_word("abort_data", data_from_mem, 64'd0);
    check_bit("abort_busy_clr", mem_busy, 1'b0);
    check_bit("abort_ready", mem_ready, 1'b0);
    check_bit("abort_fault", mem_fault, 1'b0);
    exp_rdata = 64'd0;
    @(negedge phi1);
    write_rq_to_memory = 1'b0;
    @(negedge phi1);
    rst_n = 1'b1;
    idle(2);
    txn(1'b0, 56'h8, 64'd0);
    idle(1);

    // randomized traffic: small in-range window plus out-of-range addresses
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        ra = 56'({$urandom(), $urandom()});
        ra[55:DL+3] = ra[55:DL+3] | 43'(1 << $urandom_range(0, 42));
      end else begin
        ra = 56'($urandom_range(0, 127));
      end
      txn(1'($urandom_range(0, 1)), ra, {$urandom(), $urandom()});
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the 64-bit request interface driven by the mmu: accepts read/write requests on addr_to_mem / data_to_mem and returns read data on data_from_mem.
- Backs a DEPTH-doubleword RAM with a programmable wait-state count.
- Signals completion with a one-cycle mem_ready pulse, and holds mem_busy so the core's stall logic can stretch a transaction.
- Flags out-of-range addresses with mem_fault.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 64-bit doublewords (1024 words = 8 KiB).
- LATENCY, 2, wait states from request capture to completion; legal range 1..15.

Ports:
- phi1  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- read_rq_to_memory  in  1  read request from initiator.
- write_rq_to_memory  in  1  write request from initiator.
- addr_to_mem  in  56  physical byte address.
- data_to_mem  in  64  write data.
- data_from_mem  out  64  read data; registered.
- mem_busy  out  1  transaction in flight (WAIT state).
- mem_ready  out  1  one-cycle completion pulse.
- mem_fault  out  1  completing transaction was out of range; valid with mem_ready.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State returns to IDLE; the wait counter clears.
  - data_from_mem=0, mem_busy=0, mem_ready=0, mem_fault=0.
  - RAM contents are not cleared.
  - A reset mid-transaction aborts it; no write commits.
- States: IDLE, WAIT, DONE.
- Capture: in IDLE or DONE, at a rising edge with read_rq or write_rq high:
  - latch the address, write data and op;
  - load the counter with LATENCY-1;
  - go to WAIT.
- Op select: write_rq has priority when both requests are high; the op is a write.
- WAIT:
  - mem_busy=1.
  - The counter decrements each edge.
  - At the edge where the counter is 0, commit the op and go to DONE.
  - Net: with the capture at edge E0, commit happens at edge E0+LATENCY.
- Commit, in-range read: data_from_mem <= RAM[index].
- Commit, in-range write: RAM[index] <= latched data; data_from_mem holds its previous value.
- Commit, out-of-range address:
  - read loads data_from_mem=0;
  - write is dropped;
  - mem_fault=1 in DONE.
- DONE:
  - mem_ready=1 for exactly one cycle; mem_fault is valid with it.
  - Next edge: a new request present is captured back-to-back (go to WAIT); otherwise go to IDLE, and mem_ready and mem_fault drop.
- Address decode:
  - index = addr[DEPTH_LOG2+2:3];
  - addr[2:0] ignored (doubleword access, no byte enables);
  - out of range if addr[55:DEPTH_LOG2+3] != 0.
- Request stability:
  - Inputs are sampled only at capture.
  - Request, address or data changes during WAIT are ignored; the in-flight op completes unchanged.
  - A request deasserted during WAIT does not cancel.
- Idle behaviour:
  - No request in IDLE: no state change.
  - data_from_mem holds the last read value indefinitely.
- Read-after-write to the same index in back-to-back transactions returns the new data.

Test Plan:
- Reset, then idle 5 cycles -> data_from_mem=0, mem_busy=0, mem_ready=0, mem_fault=0 throughout.
- LATENCY=2: write addr 0x40 data 0xDEADBEEF_CAFEF00D, then read 0x40 -> mem_busy high 2 cycles per op; mem_ready pulses exactly 2 edges after each capture; read returns 0xDEADBEEF_CAFEF00D.
- Read 0x47 after the above -> same data (low 3 bits ignored).
- Write 0x10 = 0x1, then write 0x20 = 0x2, issued back-to-back (second request held during DONE), then read 0x10 and 0x20 -> second captured at DONE edge with no IDLE cycle between; reads return 0x1 and 0x2.
- Read addr 0x2000 (DEPTH_LOG2=10) -> mem_ready=1, mem_fault=1, data_from_mem=0.
- Write addr 0x2000 = 0x55, then read 0x0 -> fault on the write; word 0 unchanged.
- Capture a write to 0x8 = 0xAA, assert rst_n=0 while mem_busy=1, release, read 0x8 -> outputs 0 asynchronously; read returns the pre-test value, not 0xAA.
- During WAIT, change addr and drop the request -> commit uses the original captured address; exactly one mem_ready pulse.
